// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

   localparam int DIV_MIN      = 2;
   localparam int DIVW_DEFAULT = 8;

   typedef logic [DIVW_DEFAULT-1:0] div_t;

   // Channel index width, kept at least one bit for single-channel builds.
   function automatic int ch_idx_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active ratio, one-deep pending ratio slot and
// registered clk_out/tick computed from the next state.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int DIVW        = 8,
   parameter int DEFAULT_DIV = 10
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic            sync_i,
   input  logic            wr_i,
   input  logic [DIVW-1:0] wr_div_i,
   output logic            pend_v_o,
   output logic            clk_out_o,
   output logic            tick_o
);

   localparam logic [DIVW-1:0] ONE     = DIVW'(1);
   localparam logic [DIVW-1:0] MIN_DIV = DIVW'(DIV_MIN);
   localparam logic [DIVW-1:0] DEF_DIV = DIVW'(DEFAULT_DIV);

   logic [DIVW-1:0] cnt_q, cnt_d;
   logic [DIVW-1:0] div_q, div_d;
   logic [DIVW-1:0] pend_div_q, pend_div_d;
   logic            pend_v_q, pend_v_d;
   logic            clk_out_q, clk_out_d;
   logic            tick_q, tick_d;
   logic            boundary;

   always_comb begin
      // A parked channel, a sync pulse or the last count all count as a period boundary.
      boundary   = !en_i || sync_i || (cnt_q == div_q - ONE);
      div_d      = div_q;
      pend_v_d   = pend_v_q;
      pend_div_d = pend_div_q;
      cnt_d      = cnt_q + ONE;
      if (boundary && pend_v_q) begin
         div_d    = pend_div_q;
         pend_v_d = 1'b0;
      end
      if (wr_i) begin
         pend_div_d = (wr_div_i < MIN_DIV) ? MIN_DIV : wr_div_i;
         pend_v_d   = 1'b1;
      end
      if (!en_i) begin
         cnt_d = div_d - ONE;
      end else if (boundary) begin
         cnt_d = '0;
      end
      clk_out_d = en_i && (cnt_d < (div_d >> 1));
      tick_d    = en_i && (cnt_d == div_d - ONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= DEF_DIV - ONE;
         div_q      <= DEF_DIV;
         pend_div_q <= DEF_DIV;
         pend_v_q   <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_div_q <= pend_div_d;
         pend_v_q   <= pend_v_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
      end
   end

   assign pend_v_o  = pend_v_q;
   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with glitch-free ratio updates.
// Define CLKDIV_SYNC_EN to add the sync_i phase-alignment input.
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int DIVW        = 8,
   parameter int DEFAULT_DIV = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NCH-1:0]           en_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic [ch_idx_w(NCH)-1:0] cfg_ch_i,
   input  logic [DIVW-1:0]          cfg_div_i,
`ifdef CLKDIV_SYNC_EN
   input  logic                     sync_i,
`endif
   output logic [NCH-1:0]           clk_out_o,
   output logic [NCH-1:0]           tick_o
);

   // Handshake: a ratio write transfers on a clock edge where cfg_valid_i and
   // cfg_ready_o are both high; ready only drops while the target slot is full.
   logic [NCH-1:0] pend_v;
   logic [NCH-1:0] wr;
   logic           sync;

`ifdef CLKDIV_SYNC_EN
   assign sync = sync_i;
`else
   assign sync = 1'b0;
`endif

   // Out-of-range channel indices match no slot, so they are always ready and dropped.
   always_comb begin
      cfg_ready_o = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (int'(cfg_ch_i) == i) cfg_ready_o = !pend_v[i];
      end
   end

   always_comb begin
      wr = '0;
      for (int i = 0; i < NCH; i++) begin
         wr[i] = cfg_valid_i && cfg_ready_o && (int'(cfg_ch_i) == i);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      clkdiv_chan #(
         .DIVW        (DIVW),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .en_i      (en_i[g]),
         .sync_i    (sync),
         .wr_i      (wr[g]),
         .wr_div_i  (cfg_div_i),
         .pend_v_o  (pend_v[g]),
         .clk_out_o (clk_out_o[g]),
         .tick_o    (tick_o[g])
      );
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: per-cycle expected waveforms are queued by the
// driver and checked by a negedge monitor. Covers CLKDIV_SYNC_EN when defined.
module tb_clkdiv_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] en;
   logic       cfg_valid;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic       cfg_ready, cfg_ready3;
   logic [3:0] clk_out, tick;
   logic [2:0] clk_out3, tick3;
`ifdef CLKDIV_SYNC_EN
   logic       sync;
`endif

   // entry: [3:0] clk_out, [7:4] tick, [8] ready, [9] ready checked,
   //        [10] ready of 3-channel instance, [11] that ready checked
   logic [11:0] exp_q[$];
   logic [11:0] mon_e;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   clkdiv_multi #(.NCH(4), .DIVW(8), .DEFAULT_DIV(10)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_ch_i    (cfg_ch),
      .cfg_div_i   (cfg_div),
`ifdef CLKDIV_SYNC_EN
      .sync_i      (sync),
`endif
      .clk_out_o   (clk_out),
      .tick_o      (tick)
   );

   // Three-channel copy sharing the inputs; cfg_ch=3 is out of range for it.
   clkdiv_multi #(.NCH(3), .DIVW(8), .DEFAULT_DIV(10)) u_dut3 (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en[2:0]),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready3),
      .cfg_ch_i    (cfg_ch),
      .cfg_div_i   (cfg_div),
`ifdef CLKDIV_SYNC_EN
      .sync_i      (sync),
`endif
      .clk_out_o   (clk_out3),
      .tick_o      (tick3)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("clk_out", clk_out, mon_e[3:0]);
         check("tick", tick, mon_e[7:4]);
         check("clk_out3", {1'b0, clk_out3}, {1'b0, mon_e[2:0]});
         check("tick3", {1'b0, tick3}, {1'b0, mon_e[6:4]});
         if (mon_e[9]) check("cfg_ready", {3'b0, cfg_ready}, {3'b0, mon_e[8]});
         if (mon_e[11]) check("cfg_ready3", {3'b0, cfg_ready3}, {3'b0, mon_e[10]});
      end
   end

   function automatic logic [3:0] hexd(input byte c);
      if (c >= "0" && c <= "9") return 4'(c - "0");
      return 4'(c - "A" + 8'd10);
   endfunction

   function automatic logic [11:0] mk(input logic [3:0] co, input logic [3:0] tk, input byte r);
      logic [11:0] e;
      e[3:0]  = co;
      e[7:4]  = tk;
      e[8]    = (r == "1");
      e[9]    = (r != "-");
      e[10]   = (cfg_ch == 2'd3) ? 1'b1 : e[8];
      e[11]   = e[9] || (cfg_ch == 2'd3);
      return e;
   endfunction

   // One cycle: queue the expectation for the state after the next posedge.
   task automatic step(input logic [3:0] co, input logic [3:0] tk, input byte r);
      exp_q.push_back(mk(co, tk, r));
      @(negedge clk);
      #1;
   endtask

   // Hex digit per cycle for clk_out/tick; ready chars are 0, 1 or - (unchecked).
   task automatic run_seg(input string co, input string tk, input string rdy);
      for (int i = 0; i < co.len(); i++) begin
         step(hexd(co[i]), hexd(tk[i]), (rdy.len() > i) ? rdy[i] : "-");
      end
   endtask

   initial begin
      rst       = 1'b1;
      en        = 4'b0000;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      cfg_div   = 8'd0;
`ifdef CLKDIV_SYNC_EN
      sync      = 1'b0;
`endif
      // reset state, sampled while rst is still high
      run_seg("0", "0", "1");
      rst = 1'b0;
      run_seg("0", "0", "1");

      // default D=10 on ch0 only
      en = 4'b0001;
      for (int p = 0; p < 4; p++) run_seg("1111100000", "0000000001", "1111111111");

      // ratio 4 written mid-period, takes effect at the wrap
      run_seg("111", "000", "111");
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
      run_seg("1", "0", "0");
      cfg_valid = 1'b0;
      run_seg("100000", "000001", "000000");
      run_seg("1100", "0001", "1111");
      run_seg("1100", "0001", "1111");

      // second ch0 write blocked until the wrap; ch1 write accepted meanwhile
      run_seg("1", "0", "1");
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
      run_seg("1", "0", "0");
      cfg_ch = 2'd1; cfg_div = 8'd3;
      run_seg("0", "0", "0");
      cfg_ch = 2'd0; cfg_div = 8'd8;
      run_seg("0", "1", "0");
      run_seg("1", "0", "1");
      run_seg("1", "0", "0");
      cfg_valid = 1'b0;
      run_seg("1000", "0001", "0000");
      run_seg("11110000", "00000001", "11111111");

      // clamping on ch2: 0 -> 2, 3 stays 3, 1 -> 2
      en = 4'b0000; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
      run_seg("0", "0", "0");
      cfg_valid = 1'b0;
      run_seg("0", "0", "1");
      en = 4'b0100;
      run_seg("404040", "040404", "111111");
      en = 4'b0000; cfg_valid = 1'b1; cfg_div = 8'd3;
      run_seg("0", "0", "0");
      cfg_valid = 1'b0;
      run_seg("0", "0", "1");
      en = 4'b0100;
      run_seg("400400", "004004", "111111");
      en = 4'b0000; cfg_valid = 1'b1; cfg_div = 8'd1;
      run_seg("0", "0", "0");
      cfg_valid = 1'b0;
      run_seg("0", "0", "1");
      en = 4'b0100;
      run_seg("4040", "0404", "1111");

      // ch3: real channel here, out of range for the 3-channel copy
      en = 4'b0000; cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
      run_seg("0", "0", "0");
      run_seg("0", "0", "1");
      cfg_valid = 1'b0;
      run_seg("0", "0", "1");
      en = 4'b1000;
      run_seg("8800088000", "0000800008", "1111111111");

      // asynchronous reset mid-period, asserted between edges
      en = 4'b0001; cfg_ch = 2'd0;
      run_seg("111", "000", "111");
      exp_q.push_back(mk(4'h0, 4'h0, "1"));
      #6 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      en = 4'b1111;
      run_seg("FFFFF00000", "000000000F", "1111111111");
      run_seg("FFFFF00000", "000000000F", "1111111111");

`ifdef CLKDIV_SYNC_EN
      // ch0 D=6 and ch1 D=3 started out of phase, then aligned by sync
      en = 4'b0000; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
      run_seg("0", "0", "0");
      cfg_ch = 2'd1; cfg_div = 8'd3;
      run_seg("0", "0", "0");
      cfg_valid = 1'b0;
      run_seg("0", "0", "1");
      en = 4'b0001;
      run_seg("1", "0", "1");
      en = 4'b0011;
      run_seg("3102013", "0020120", "1111111");
      sync = 1'b1;
      run_seg("3", "0", "1");
      sync = 1'b0;
      run_seg("11200", "02003", "11111");
      run_seg("311200", "002003", "111111");
      run_seg("311200", "002003", "111111");
`endif

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
